receptor_medida_serial: RTL

RECEPTOR_MEDIDA_SERIAL -- requirements
Module: receptor_medida_serial

---
 rtl/receptor_medida_serial_pkg.sv | 33 +++
 rtl/rx_serial_7O1.sv | 115 +++++++++++
 rtl/receptor_medida_serial.sv | 127 ++++++++++++
 3 files changed

// File: rtl/receptor_medida_serial_pkg.sv
// Shared constants for the serial measurement receiver:
// character codes, frame/receiver state encodings, default bit timing.
package receptor_medida_serial_pkg;

  localparam int CLKS_PER_BIT_PADRAO = 434;

  localparam logic [6:0] HEXA_30 = 7'h30;
  localparam logic [6:0] HEXA_23 = 7'h23;

  typedef enum logic [2:0] {
    ESPERA_D0  = 3'd0,
    ESPERA_D1  = 3'd1,
    ESPERA_D2  = 3'd2,
    ESPERA_FIM = 3'd3
  } estado_quadro_t;

  typedef enum logic [2:0] {
    RX_OCIOSO,
    RX_INICIO,
    RX_DADOS,
    RX_PARIDADE,
    RX_PARADA
  } rx_estado_t;

  // Odd parity holds when data plus parity bit carry an odd count of ones.
  function automatic logic paridade_ok(
    input logic [6:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/rx_serial_7O1.sv
// 7O1 UART character receiver: synchronizer, bit timing, parity/stop check.
// Ports: clock, reset (sync, low), rx -> dado[6:0], dado_valido, erro_paridade, erro_quadro.
module rx_serial_7O1
  import receptor_medida_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [6:0] dado,
  output logic       dado_valido,
  output logic       erro_paridade,
  output logic       erro_quadro
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_UM   = CW'(1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MEIO = CW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic rx_s, rx_ant;

  rx_estado_t    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [6:0]    sr, sr_n;
  logic          par, par_n;
  logic          tick;

  assign rx_s = sync[SYNC_STAGES-1];
  assign tick = (cnt == CNT_BIT);
  assign dado = sr;

  // Synchronizer and edge history reset low so a line that is
  // already low at release never looks like a fresh start edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync   <= '0;
      rx_ant <= 1'b0;
      st     <= RX_OCIOSO;
      cnt    <= '0;
      idx    <= '0;
      sr     <= '0;
      par    <= 1'b0;
    end else begin
      sync[0] <= rx;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
      rx_ant <= rx_s;
      st     <= st_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sr     <= sr_n;
      par    <= par_n;
    end
  end

  always_comb begin
    st_n          = st;
    cnt_n         = cnt + CNT_UM;
    idx_n         = idx;
    sr_n          = sr;
    par_n         = par;
    dado_valido   = 1'b0;
    erro_paridade = 1'b0;
    erro_quadro   = 1'b0;
    unique case (st)
      RX_OCIOSO: begin
        cnt_n = '0;
        if (!rx_s && rx_ant)
          st_n = RX_INICIO;
      end
      RX_INICIO: begin
        if (cnt == CNT_MEIO) begin
          cnt_n = '0;
          idx_n = '0;
          st_n  = rx_s ? RX_OCIOSO : RX_DADOS;
        end
      end
      RX_DADOS: begin
        if (tick) begin
          cnt_n = '0;
          sr_n  = {rx_s, sr[6:1]};
          idx_n = idx + 3'd1;
          if (idx == 3'd6)
            st_n = RX_PARIDADE;
        end
      end
      RX_PARIDADE: begin
        if (tick) begin
          cnt_n = '0;
          par_n = rx_s;
          st_n  = RX_PARADA;
        end
      end
      RX_PARADA: begin
        if (tick) begin
          cnt_n = '0;
          st_n  = RX_OCIOSO;
          if (!rx_s)
            erro_quadro = 1'b1;
          else if (!paridade_ok(sr, par))
            erro_paridade = 1'b1;
          else
            dado_valido = 1'b1;
        end
      end
      default: st_n = RX_OCIOSO;
    endcase
  end

endmodule

// File: rtl/receptor_medida_serial.sv
// Receives "DDD#" frames over 7O1 serial and publishes a 12-bit distance.
// Ports: clock, reset (sync, low), RX -> distancia, pulses, db_estado.
module receptor_medida_serial
  import receptor_medida_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] distancia,
  output logic        medida_valida,
  output logic        erro_paridade,
  output logic        erro_quadro,
  output logic        erro_formato,
  output logic [2:0]  db_estado
);

  logic [6:0] dado;
  logic       rx_ok, rx_par, rx_qd;

  rx_serial_7O1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .rx            (RX),
    .dado          (dado),
    .dado_valido   (rx_ok),
    .erro_paridade (rx_par),
    .erro_quadro   (rx_qd)
  );

  estado_quadro_t estado, estado_n;
  logic [11:0] nib, nib_n;
  logic [11:0] dist_n;
  logic        mv_n, ep_n, eq_n, ef_n;
  logic [6:0]  dif;
  logic        eh_dig, eh_fim;

  // A digit is any code whose offset from '0' stays below 16.
  assign dif    = dado - HEXA_30;
  assign eh_dig = (dif[6:4] == 3'd0);
  assign eh_fim = (dado == HEXA_23);

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= ESPERA_D0;
      nib           <= '0;
      distancia     <= '0;
      medida_valida <= 1'b0;
      erro_paridade <= 1'b0;
      erro_quadro   <= 1'b0;
      erro_formato  <= 1'b0;
    end else begin
      estado        <= estado_n;
      nib           <= nib_n;
      distancia     <= dist_n;
      medida_valida <= mv_n;
      erro_paridade <= ep_n;
      erro_quadro   <= eq_n;
      erro_formato  <= ef_n;
    end
  end

  always_comb begin
    estado_n = estado;
    nib_n    = nib;
    dist_n   = distancia;
    mv_n     = 1'b0;
    ep_n     = 1'b0;
    eq_n     = 1'b0;
    ef_n     = 1'b0;
    if (rx_qd) begin
      eq_n     = 1'b1;
      estado_n = ESPERA_D0;
    end else if (rx_par) begin
      ep_n     = 1'b1;
      estado_n = ESPERA_D0;
    end else if (rx_ok) begin
      unique case (estado)
        ESPERA_D0: begin
          if (eh_dig) begin
            nib_n[11:8] = dif[3:0];
            estado_n    = ESPERA_D1;
          end else begin
            ef_n     = !eh_fim;
            estado_n = ESPERA_D0;
          end
        end
        ESPERA_D1: begin
          if (eh_dig) begin
            nib_n[7:4] = dif[3:0];
            estado_n   = ESPERA_D2;
          end else begin
            ef_n     = 1'b1;
            estado_n = ESPERA_D0;
          end
        end
        ESPERA_D2: begin
          if (eh_dig) begin
            nib_n[3:0] = dif[3:0];
            estado_n   = ESPERA_FIM;
          end else begin
            ef_n     = 1'b1;
            estado_n = ESPERA_D0;
          end
        end
        ESPERA_FIM: begin
          if (eh_fim) begin
            dist_n = nib;
            mv_n   = 1'b1;
          end else begin
            ef_n = 1'b1;
          end
          estado_n = ESPERA_D0;
        end
        default: estado_n = ESPERA_D0;
      endcase
    end
  end

endmodule
